// File: rtl/sort_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// sort_run_ctrl_if
//   Groups the bus signals around the sort run controller into one bundle:
//   the host memory-access port, the datapath control/observation port and
//   the single data-memory port that the controller arbitrates.
//
//   modport slave  : view taken by the run controller
//   modport master : view taken by the surrounding system (host, datapath,
//                    data memory)
//
//   Signals
//     host_req/host_we/host_addr/host_wdata : host access request (to ctrl)
//     host_gnt/host_rdata                   : grant and read data (from ctrl)
//     core_en/core_clr                      : datapath enable / PC clear
//     core_ins                              : instruction seen by datapath
//     core_mem_we/core_mem_addr/core_mem_wdata : datapath store request
//     mem_we/mem_addr/mem_wdata             : arbitrated memory port
//     mem_rdata                             : synchronous memory read data
// ---------------------------------------------------------------------------
interface sort_run_ctrl_if #(
  parameter int AW = 10
);
  // host side
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata;
  logic          host_gnt;
  logic [31:0]   host_rdata;

  // datapath side
  logic          core_en;
  logic          core_clr;
  logic [31:0]   core_ins;
  logic          core_mem_we;
  logic [AW-1:0] core_mem_addr;
  logic [31:0]   core_mem_wdata;

  // data-memory side
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rdata,
    output core_en, core_clr,
    input  core_ins, core_mem_we, core_mem_addr, core_mem_wdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rdata,
    input  core_en, core_clr,
    output core_ins, core_mem_we, core_mem_addr, core_mem_wdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/sort_run_ctrl.sv
// ---------------------------------------------------------------------------
// sort_run_ctrl
//   Run controller for the single-cycle sorting datapath. Sequences a job
//   (host preload, datapath clear, free-run, halt / timeout detection, host
//   readout), arbitrates the one data-memory port between host and datapath
//   and counts run cycles.
//
//   Ports
//     clk          : system clock, rising edge
//     rst          : asynchronous active-low reset
//     start        : one-cycle pulse, begins (or reruns) a job
//     abort        : one-cycle pulse, cancels a job and returns to IDLE
//     bus          : host / datapath / memory bundle (slave view)
//     busy         : high in CLEAR and RUN
//     done         : high after the datapath executed the halt instruction
//     timeout      : high after the run-cycle limit was reached
//     cycle_count  : run cycles of the current or last job
// ---------------------------------------------------------------------------
module sort_run_ctrl #(
  parameter int          AW         = 10,
  parameter int          MAX_CYCLES = 100000,
  parameter logic [31:0] HALT_INSN  = 32'h0000_006F
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  sort_run_ctrl_if.slave       bus,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [31:0]          cycle_count
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_TOUT  = 3'd4
  } state_t;

  // A limit of zero switches the timeout off entirely.
  localparam bit          TIMEOUT_EN = (MAX_CYCLES != 0);
  localparam logic [31:0] LAST_CYCLE = TIMEOUT_EN ? 32'(MAX_CYCLES - 1) : 32'd0;

  state_t      state_q, state_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic        core_en_q, core_en_d;
  logic        core_clr_q, core_clr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;

  logic        halt_s;
  logic        limit_s;
  logic        host_owner_s;
  logic        host_gnt_s;
  logic        mem_we_s;
  logic [AW-1:0] mem_addr_s;
  logic [31:0] mem_wdata_s;

  // Host may use the memory port only while the datapath is parked.
  function automatic logic host_owns(input state_t st);
    case (st)
      ST_IDLE, ST_DONE, ST_TOUT: host_owns = 1'b1;
      default:                   host_owns = 1'b0;
    endcase
  endfunction

  assign halt_s  = (bus.core_ins == HALT_INSN);
  assign limit_s = TIMEOUT_EN && (cycle_count_q == LAST_CYCLE);

  // Next-state logic; status flags are derived from the next state so that
  // they are registered and line up with the state they describe.
  always_comb begin
    state_d       = state_q;
    cycle_count_d = cycle_count_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_d       = ST_RUN;
        cycle_count_d = 32'd0;
      end
      ST_RUN: begin
        // abort freezes the count; otherwise the current cycle is counted,
        // including the halt cycle and the last cycle before timeout.
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          cycle_count_d = cycle_count_q + 32'd1;
          if (halt_s) begin
            state_d = ST_DONE;
          end else if (limit_s) begin
            state_d = ST_TOUT;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_DONE, ST_TOUT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    core_en_d  = (state_d == ST_RUN);
    core_clr_d = (state_d == ST_CLEAR);
    busy_d     = (state_d == ST_CLEAR) || (state_d == ST_RUN);
    done_d     = (state_d == ST_DONE);
    timeout_d  = (state_d == ST_TOUT);
  end

  // State, counter and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cycle_count_q <= 32'd0;
      core_en_q     <= 1'b0;
      core_clr_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
      core_en_q     <= core_en_d;
      core_clr_q    <= core_clr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
    end
  end

  assign host_owner_s = host_owns(state_q);
  assign host_gnt_s   = bus.host_req && host_owner_s;

  // Memory-port mux. Driven from the state register so an asynchronous
  // reset immediately hands the port back to the (idle) host and no core
  // store can slip through after reset assertion.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_addr_s  = bus.host_addr;
    mem_wdata_s = bus.host_wdata;
    case (state_q)
      ST_RUN: begin
        mem_we_s    = bus.core_mem_we;
        mem_addr_s  = bus.core_mem_addr;
        mem_wdata_s = bus.core_mem_wdata;
      end
      ST_CLEAR: begin
        // Datapath is being reset and the host is blocked: no writes.
        mem_we_s    = 1'b0;
        mem_addr_s  = bus.core_mem_addr;
        mem_wdata_s = bus.core_mem_wdata;
      end
      ST_IDLE, ST_DONE, ST_TOUT: begin
        mem_we_s    = host_gnt_s && bus.host_we;
        mem_addr_s  = bus.host_addr;
        mem_wdata_s = bus.host_wdata;
      end
      default: begin
        mem_we_s    = 1'b0;
        mem_addr_s  = bus.host_addr;
        mem_wdata_s = bus.host_wdata;
      end
    endcase
  end

  assign bus.host_gnt   = host_gnt_s;
  assign bus.host_rdata = bus.mem_rdata;
  assign bus.mem_we     = mem_we_s;
  assign bus.mem_addr   = mem_addr_s;
  assign bus.mem_wdata  = mem_wdata_s;
  assign bus.core_en    = core_en_q;
  assign bus.core_clr   = core_clr_q;

  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_sort_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sort_run_ctrl
//   Directed bench for sort_run_ctrl. Instance A uses the default run limit
//   and owns a small synchronous memory model; instance B uses a 16-cycle
//   limit for the timeout scenarios. The datapath is modelled by driving
//   core_ins / core stores directly.
// ---------------------------------------------------------------------------
module tb_sort_run_ctrl;
  localparam int          AW   = 10;
  localparam logic [31:0] HALT = 32'h0000_006F;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, abort_a, busy_a, done_a, tout_a;
  logic [31:0] cnt_a;
  logic        start_b, abort_b, busy_b, done_b, tout_b;
  logic [31:0] cnt_b;
  logic        halt_en_a, halt_en_b;
  logic [31:0] halt_at_a, halt_at_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sort_run_ctrl_if #(.AW(AW)) ifa ();
  sort_run_ctrl_if #(.AW(AW)) ifb ();

  sort_run_ctrl #(.AW(AW)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .bus(ifa),
    .busy(busy_a), .done(done_a), .timeout(tout_a), .cycle_count(cnt_a)
  );

  sort_run_ctrl #(.AW(AW), .MAX_CYCLES(16)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .bus(ifb),
    .busy(busy_b), .done(done_b), .timeout(tout_b), .cycle_count(cnt_b)
  );

  // Datapath model: presents the halt word when the run count hits halt_at.
  assign ifa.core_ins = (halt_en_a && cnt_a == halt_at_a) ? HALT : NOP;
  assign ifb.core_ins = (halt_en_b && cnt_b == halt_at_b) ? HALT : NOP;

  // Synchronous data memory for instance A.
  logic [31:0] mem_a [0:(1<<AW)-1];
  logic [31:0] rdata_a;
  always @(posedge clk) begin
    if (ifa.mem_we) mem_a[ifa.mem_addr] <= ifa.mem_wdata;
    rdata_a <= mem_a[ifa.mem_addr];
  end
  assign ifa.mem_rdata = rdata_a;
  assign ifb.mem_rdata = 32'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || tout_a !== 1'b0) begin
      errors++; $display("FAIL reset_status: got busy=%b done=%b tout=%b, want 0 0 0", busy_a, done_a, tout_a);
    end
    checks++;
    if (ifa.core_en !== 1'b0 || ifa.core_clr !== 1'b0 || ifa.mem_we !== 1'b0) begin
      errors++; $display("FAIL reset_core: got en=%b clr=%b mem_we=%b, want 0 0 0", ifa.core_en, ifa.core_clr, ifa.mem_we);
    end
    checks++;
    if (cnt_a !== 32'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", cnt_a);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_load_run_halt();
    int runs = 0;
    int gnt_bad = 0;
    halt_en_a = 1'b1;
    halt_at_a = 32'd39;
    // Preload 8 words; start rides along with the last write.
    for (int i = 0; i < 8; i++) begin
      ifa.host_req   = 1'b1;
      ifa.host_we    = 1'b1;
      ifa.host_addr  = AW'(i);
      ifa.host_wdata = 32'h1000_0000 + 32'(i);
      start_a        = (i == 7);
      #1;
      if (ifa.host_gnt !== 1'b1) gnt_bad++;
      tick();
    end
    start_a     = 1'b0;
    ifa.host_we = 1'b0;
    ifa.host_addr = '0;
    checks++;
    if (gnt_bad != 0) begin
      errors++; $display("FAIL preload_gnt: %0d ungranted cycles, want 0", gnt_bad);
    end
    checks++;
    if (ifa.core_clr !== 1'b1 || busy_a !== 1'b1 || ifa.core_en !== 1'b0 || ifa.host_gnt !== 1'b0) begin
      errors++; $display("FAIL clear_state: got clr=%b busy=%b en=%b gnt=%b, want 1 1 0 0",
                         ifa.core_clr, busy_a, ifa.core_en, ifa.host_gnt);
    end
    checks++;
    if (mem_a[7] !== 32'h1000_0007) begin
      errors++; $display("FAIL write_with_start: mem[7]=%h want 10000007", mem_a[7]);
    end
    gnt_bad = 0;
    for (int c = 0; c < 200 && !done_a; c++) begin
      tick();
      if (ifa.core_en === 1'b1) runs++;
      if (!done_a && ifa.host_gnt !== 1'b0) gnt_bad++;
    end
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || ifa.core_en !== 1'b0 || cnt_a !== 32'd40) begin
      errors++; $display("FAIL halt_done: got done=%b busy=%b en=%b cnt=%0d, want 1 0 0 40",
                         done_a, busy_a, ifa.core_en, cnt_a);
    end
    checks++;
    if (runs != 40 || gnt_bad != 0) begin
      errors++; $display("FAIL halt_runs: got runs=%0d gnt_bad=%0d, want 40 0", runs, gnt_bad);
    end
    // Readout of word 2 after DONE.
    ifa.host_addr = AW'(2);
    #1;
    checks++;
    if (ifa.host_gnt !== 1'b1) begin
      errors++; $display("FAIL done_gnt: got %b want 1", ifa.host_gnt);
    end
    tick();
    checks++;
    if (ifa.host_rdata !== 32'h1000_0002) begin
      errors++; $display("FAIL readout: got %h want 10000002", ifa.host_rdata);
    end
    ifa.host_req = 1'b0;
  endtask

  task automatic test_arbitration();
    int gnt_bad = 0;
    halt_en_a = 1'b1;
    halt_at_a = 32'd39;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    ifa.host_req   = 1'b1;
    ifa.host_we    = 1'b1;
    ifa.host_addr  = AW'(5);
    ifa.host_wdata = 32'hDEAD_BEEF;
    ifa.core_mem_addr  = AW'(3);
    ifa.core_mem_wdata = 32'hCAFE_F00D;
    for (int c = 0; c < 200 && !done_a; c++) begin
      ifa.core_mem_we = (ifa.core_en === 1'b1) && (cnt_a == 32'd5);
      #1;
      if (ifa.host_gnt !== 1'b0) gnt_bad++;
      tick();
    end
    ifa.core_mem_we = 1'b0;
    checks++;
    if (gnt_bad != 0 || done_a !== 1'b1) begin
      errors++; $display("FAIL arb_gnt: got gnt_bad=%0d done=%b, want 0 1", gnt_bad, done_a);
    end
    checks++;
    if (mem_a[3] !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL core_store: mem[3]=%h want cafef00d", mem_a[3]);
    end
    checks++;
    if (mem_a[5] !== 32'h1000_0005) begin
      errors++; $display("FAIL blocked_host_write: mem[5]=%h want 10000005", mem_a[5]);
    end
    ifa.host_we   = 1'b0;
    ifa.host_addr = AW'(3);
    tick();
    checks++;
    if (ifa.host_rdata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL host_read_core_data: got %h want cafef00d", ifa.host_rdata);
    end
    ifa.host_req = 1'b0;
  endtask

  task automatic test_abort_rerun();
    int guard = 0;
    halt_en_a = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    while (cnt_a != 32'd10 && guard < 100) begin
      start_a = (cnt_a == 32'd5) && (ifa.core_en === 1'b1);
      tick();
      guard++;
    end
    start_a = 1'b0;
    checks++;
    if (busy_a !== 1'b1 || ifa.core_en !== 1'b1 || cnt_a !== 32'd10) begin
      errors++; $display("FAIL start_ignored: got busy=%b en=%b cnt=%0d, want 1 1 10", busy_a, ifa.core_en, cnt_a);
    end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || tout_a !== 1'b0 || ifa.core_en !== 1'b0 || cnt_a !== 32'd10) begin
      errors++; $display("FAIL abort: got busy=%b done=%b tout=%b en=%b cnt=%0d, want 0 0 0 0 10",
                         busy_a, done_a, tout_a, ifa.core_en, cnt_a);
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++;
    if (ifa.core_clr !== 1'b1 || ifa.core_en !== 1'b0 || busy_a !== 1'b1) begin
      errors++; $display("FAIL rerun_clear: got clr=%b en=%b busy=%b, want 1 0 1", ifa.core_clr, ifa.core_en, busy_a);
    end
    tick();
    checks++;
    if (ifa.core_clr !== 1'b0 || ifa.core_en !== 1'b1 || cnt_a !== 32'd0) begin
      errors++; $display("FAIL rerun_first: got clr=%b en=%b cnt=%0d, want 0 1 0", ifa.core_clr, ifa.core_en, cnt_a);
    end
    tick();
    checks++;
    if (cnt_a !== 32'd1) begin
      errors++; $display("FAIL rerun_count: got %0d want 1", cnt_a);
    end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
  endtask

  task automatic test_timeout();
    int runs = 0;
    halt_en_b = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int c = 0; c < 100 && !tout_b; c++) begin
      tick();
      if (ifb.core_en === 1'b1) runs++;
    end
    checks++;
    if (tout_b !== 1'b1 || done_b !== 1'b0 || ifb.core_en !== 1'b0 || cnt_b !== 32'd16 || runs != 16) begin
      errors++; $display("FAIL timeout: got tout=%b done=%b en=%b cnt=%0d runs=%0d, want 1 0 0 16 16",
                         tout_b, done_b, ifb.core_en, cnt_b, runs);
    end
    tick();
    checks++;
    if (cnt_b !== 32'd16 || ifb.core_en !== 1'b0 || tout_b !== 1'b1) begin
      errors++; $display("FAIL timeout_frozen: got cnt=%0d en=%b tout=%b, want 16 0 1", cnt_b, ifb.core_en, tout_b);
    end
    start_b = 1'b1;
    abort_b = 1'b1;
    tick();
    start_b = 1'b0;
    abort_b = 1'b0;
    checks++;
    if (tout_b !== 1'b0 || busy_b !== 1'b0 || ifb.core_clr !== 1'b0) begin
      errors++; $display("FAIL abort_beats_start: got tout=%b busy=%b clr=%b, want 0 0 0", tout_b, busy_b, ifb.core_clr);
    end
  endtask

  task automatic test_halt_on_limit();
    halt_en_b = 1'b1;
    halt_at_b = 32'd15;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int c = 0; c < 100 && !done_b && !tout_b; c++) tick();
    checks++;
    if (done_b !== 1'b1 || tout_b !== 1'b0 || cnt_b !== 32'd16) begin
      errors++; $display("FAIL halt_on_limit: got done=%b tout=%b cnt=%0d, want 1 0 16", done_b, tout_b, cnt_b);
    end
  endtask

  task automatic test_reset_mid_run();
    halt_en_a = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 0; c < 100 && cnt_a != 32'd3; c++) tick();
    ifa.core_mem_we    = 1'b1;
    ifa.core_mem_addr  = AW'(9);
    ifa.core_mem_wdata = 32'h0000_0001;
    #1;
    checks++;
    if (ifa.mem_we !== 1'b1 || ifa.core_en !== 1'b1) begin
      errors++; $display("FAIL pre_reset_run: got mem_we=%b en=%b, want 1 1", ifa.mem_we, ifa.core_en);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ifa.core_en !== 1'b0 || ifa.mem_we !== 1'b0 || busy_a !== 1'b0 || cnt_a !== 32'd0) begin
      errors++; $display("FAIL reset_mid_run: got en=%b mem_we=%b busy=%b cnt=%0d, want 0 0 0 0",
                         ifa.core_en, ifa.mem_we, busy_a, cnt_a);
    end
    ifa.core_mem_we = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    halt_en_a = 1'b0; halt_en_b = 1'b0; halt_at_a = 32'd0; halt_at_b = 32'd0;
    ifa.host_req = 1'b0; ifa.host_we = 1'b0; ifa.host_addr = '0; ifa.host_wdata = 32'd0;
    ifa.core_mem_we = 1'b0; ifa.core_mem_addr = '0; ifa.core_mem_wdata = 32'd0;
    ifb.host_req = 1'b0; ifb.host_we = 1'b0; ifb.host_addr = '0; ifb.host_wdata = 32'd0;
    ifb.core_mem_we = 1'b0; ifb.core_mem_addr = '0; ifb.core_mem_wdata = 32'd0;
    test_reset();
    test_load_run_halt();
    test_arbitration();
    test_abort_rerun();
    test_timeout();
    test_halt_on_limit();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sort_run_ctrl.md
Name: sort_run_ctrl

Overview:
Run controller for the single-cycle sorting datapath. It sequences each sort job: host preload of data memory, core clear, free-run, halt detection, timeout and host readout. It also arbitrates the single data-memory port between the host and the core, and exposes a run-cycle counter for performance measurement.

Parameters:
AW, 10, data-memory word-address width
MAX_CYCLES, 100000, run-cycle limit before timeout; 0 disables timeout
HALT_INSN, 32'h0000006F, halt encoding (JAL x0,0 self-loop)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; begins a job
abort  in  1  single-cycle pulse; cancels a running job
host_req  in  1  host memory access request
host_we  in  1  host write enable, qualified by host_req
host_addr  in  AW  host word address
host_wdata  in  32  host write data
host_gnt  out  1  host access accepted this cycle
host_rdata  out  32  mem_rdata passthrough
core_en  out  1  PC/regfile update enable for the datapath
core_clr  out  1  synchronous clear of the datapath PC to 0
core_ins  in  32  current instruction from the datapath
core_mem_we  in  1  core store enable
core_mem_addr  in  AW  core word address
core_mem_wdata  in  32  core store data
mem_we  out  1  data-memory write enable
mem_addr  out  AW  data-memory address
mem_wdata  out  32  data-memory write data
mem_rdata  in  32  data-memory read data
busy  out  1  high in CLEAR and RUN
done  out  1  high in DONE
timeout  out  1  high in TOUT
cycle_count  out  32  run cycles of the current or last job

Behaviour:
- Reset (rst low, async): state=IDLE; cycle_count=0; core_en=0; core_clr=0; busy, done and timeout all 0. Memory outputs follow the IDLE mux with host_req low, so mem_we=0.
- States: IDLE, CLEAR, RUN, DONE, TOUT. State and status outputs are registered; the mux and host_gnt are combinational from the state.
- IDLE: start -> CLEAR. Host owns the memory port.
- CLEAR (1 cycle): core_clr=1, core_en=0, cycle_count<=0 -> RUN. Host is blocked.
- RUN: core_en=1 and the core owns the port: mem_we=core_mem_we, mem_addr=core_mem_addr, mem_wdata=core_mem_wdata. cycle_count increments every RUN cycle. Transitions:
  - core_ins==HALT_INSN -> DONE next cycle. The halt cycle is counted; no further increment.
  - MAX_CYCLES!=0 and cycle_count==MAX_CYCLES-1 with no halt -> TOUT.
  - Halt and timeout in the same cycle: halt wins (DONE).
  - abort -> IDLE; cycle_count holds its value.
  - abort has priority over halt and timeout.
  - start is ignored.
- DONE/TOUT: core_en=0, host owns the port for readout, cycle_count frozen. start -> CLEAR (rerun). abort -> IDLE. start and abort together: abort wins.
- Host arbitration:
  - host_gnt = host_req and state in {IDLE, DONE, TOUT}.
  - When granted: mem_we=host_we, mem_addr=host_addr, mem_wdata=host_wdata.
  - When not granted: the host is stalled and must hold its request; its write is never performed.
  - host_rdata is valid the cycle after a granted read (synchronous memory).
- Simultaneous start and host write in IDLE: the write completes this cycle; CLEAR begins next cycle.
- Reset mid-RUN: immediate return to IDLE, core_en drops asynchronously, no memory write is issued after reset assertion.
- busy = state in {CLEAR, RUN}.

Test Plan:
- Reset: assert rst=0 mid-RUN -> IDLE, core_en=0, cycle_count=0, mem_we=0 immediately.
- Load/run/halt: host writes 8 words at 0..7; start; core halts at its 40th RUN cycle -> done=1, cycle_count=40, host_gnt=0 throughout CLEAR/RUN.
- Timeout: MAX_CYCLES=16, program never halts -> timeout=1, cycle_count=16, core_en=0 from the next cycle.
- Halt on the limit cycle: HALT_INSN presented when cycle_count==MAX_CYCLES-1 -> DONE, not TOUT.
- Arbitration: host_req=1, host_we=1, addr=5 during RUN -> host_gnt=0, core store to addr 3 lands in memory. After DONE, the host reads addr 3 -> host_rdata equals the core data one cycle later.
- Abort and rerun: abort at RUN cycle 10 -> IDLE, cycle_count=10. Then start -> core_clr pulses for 1 cycle, cycle_count restarts from 0.
